// File: rtl/uart_bridge_responder_pkg.sv
// Shared register map, bit positions and sizing defaults for the UART bridge responder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_bridge_responder_pkg;

    localparam int FIFO_DEPTH_DEF = 16;

    // Word offsets decoded from bridge_uart_address[5:2]
    localparam logic [3:0] OFS_DATA    = 4'h0;
    localparam logic [3:0] OFS_STATUS  = 4'h1;
    localparam logic [3:0] OFS_CONTROL = 4'h2;

    // DATA read bit positions
    localparam int DATA_RVALID = 15;

    // STATUS bit positions
    localparam int ST_RX_CNT_LSB = 0;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_OVR     = 16;
    localparam int ST_TX_OVF     = 17;

    // CONTROL bit positions
    localparam int CTL_RX_IRQ_EN       = 0;
    localparam int CTL_TX_EMPTY_IRQ_EN = 1;
    localparam int CTL_LOOPBACK        = 2;

endpackage

// File: rtl/uart_bridge_responder_fifo.sv
// Synchronous first-word-fall-through byte FIFO with an occupancy count.
// Latency: a pushed byte is visible on pop_dat the cycle after the push edge.
// Backpressure: pushes while full are dropped; pops while empty are ignored.
module bridge_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             push_vld,
    input  logic [7:0]       push_dat,
    input  logic             pop_rdy,
    output logic [7:0]       pop_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push_vld & ~full;
    assign do_pop  = pop_rdy & ~empty;
    assign pop_dat = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so it is not reset
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count never passes DEPTH
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_bridge_responder.sv
// Register-mapped bus responder bridging a request/acknowledge bus to UART RX/TX byte FIFOs.
// Latency: acknowledge and read data one cycle after the request; loopback moves one byte per cycle.
// Backpressure: TX drains on tx_valid & tx_ready; full-FIFO writes and RX strobes are dropped and flagged.
module uart_bridge_responder
    import uart_bridge_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        bridge_uart_read,
    input  logic        bridge_uart_write,
    input  logic [3:0]  bridge_uart_byte_enable,
    input  logic [5:0]  bridge_uart_address,
    input  logic [31:0] bridge_uart_write_data,
    output logic        bridge_uart_acknowledge,
    output logic [31:0] bridge_uart_read_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq
);
    logic [3:0]       offset;
    logic             req;
    logic             ack_rise;
    logic             is_read;
    logic             is_write;
    logic [31:0]      rd_val;
    logic [2:0]       ctrl;
    logic             rx_ovr;
    logic             tx_ovf;
    logic             loopback;

    logic             rx_push_vld;
    logic [7:0]       rx_push_dat;
    logic             rx_pop_rdy;
    logic [7:0]       rx_dat;
    logic [CNT_W-1:0] rx_count;
    logic             rx_full;
    logic             rx_empty;

    logic             tx_push_vld;
    logic             tx_pop_rdy;
    logic [7:0]       tx_dat;
    logic [CNT_W-1:0] tx_count;
    logic             tx_full;
    logic             tx_empty;

    logic             lb_move;
    logic             status_clr;
    logic             unused_bits;

    assign offset   = bridge_uart_address[5:2];
    assign req      = bridge_uart_read | bridge_uart_write;
    assign ack_rise = req & ~bridge_uart_acknowledge;
    assign is_read  = bridge_uart_read;
    assign is_write = bridge_uart_write & ~bridge_uart_read;   // read wins a collision
    assign loopback = ctrl[CTL_LOOPBACK];

    assign lb_move     = loopback & ~tx_empty & ~rx_full;
    assign rx_push_vld = loopback ? lb_move : rx_valid;
    assign rx_push_dat = loopback ? tx_dat  : rx_data;
    assign rx_pop_rdy  = ack_rise & is_read & (offset == OFS_DATA) & ~rx_empty;
    assign tx_push_vld = ack_rise & is_write & (offset == OFS_DATA) & bridge_uart_byte_enable[0];
    assign tx_pop_rdy  = loopback ? lb_move : (tx_ready & ~tx_empty);
    assign status_clr  = ack_rise & is_write & (offset == OFS_STATUS) & bridge_uart_byte_enable[2];

    assign tx_valid = ~loopback & ~tx_empty;
    assign tx_data  = tx_valid ? tx_dat : 8'h00;

    assign unused_bits = ^{bridge_uart_address[1:0], bridge_uart_byte_enable[3],
                           bridge_uart_byte_enable[1], bridge_uart_write_data[31:18],
                           bridge_uart_write_data[15:8]};

    bridge_byte_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
        .clock    (clock),
        .nreset   (nreset),
        .push_vld (rx_push_vld),
        .push_dat (rx_push_dat),
        .pop_rdy  (rx_pop_rdy),
        .pop_dat  (rx_dat),
        .count    (rx_count),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    bridge_byte_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
        .clock    (clock),
        .nreset   (nreset),
        .push_vld (tx_push_vld),
        .push_dat (bridge_uart_write_data[7:0]),
        .pop_rdy  (tx_pop_rdy),
        .pop_dat  (tx_dat),
        .count    (tx_count),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    // Read mux for the addressed register, sampled on the acknowledge-rise edge
    always_comb begin
        rd_val = '0;
        case (offset)
            OFS_DATA: begin
                if (!rx_empty) begin
                    rd_val[7:0]         = rx_dat;
                    rd_val[DATA_RVALID] = 1'b1;
                end
            end
            OFS_STATUS: begin
                rd_val[ST_RX_CNT_LSB +: 5] = 5'(rx_count);
                rd_val[ST_TX_CNT_LSB +: 5] = 5'(tx_count);
                rd_val[ST_RX_OVR]          = rx_ovr;
                rd_val[ST_TX_OVF]          = tx_ovf;
            end
            OFS_CONTROL: rd_val[2:0] = ctrl;
            default: ;
        endcase
    end

    // Acknowledge tracks the request one edge late; read data is held only while acknowledged
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            bridge_uart_acknowledge <= 1'b0;
            bridge_uart_read_data   <= '0;
        end else begin
            bridge_uart_acknowledge <= req;
            if (ack_rise) begin
                bridge_uart_read_data <= is_read ? rd_val : 32'h0;
            end else if (!req) begin
                bridge_uart_read_data <= '0;
            end
        end
    end

    // CONTROL register and sticky error flags (a new error wins over a same-cycle clear)
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            ctrl   <= '0;
            rx_ovr <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            if (ack_rise && is_write && offset == OFS_CONTROL && bridge_uart_byte_enable[0]) begin
                ctrl <= bridge_uart_write_data[2:0];
            end
            rx_ovr <= (rx_ovr & ~(status_clr & bridge_uart_write_data[ST_RX_OVR]))
                    | (~loopback & rx_valid & rx_full);
            tx_ovf <= (tx_ovf & ~(status_clr & bridge_uart_write_data[ST_TX_OVF]))
                    | (tx_push_vld & tx_full);
        end
    end

    // Registered level interrupt
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            irq <= 1'b0;
        end else begin
            irq <= (ctrl[CTL_RX_IRQ_EN] & (rx_count != '0))
                 | (ctrl[CTL_TX_EMPTY_IRQ_EN] & (tx_count == '0));
        end
    end

endmodule
